// File: rtl/adder_serial16_pkg.sv
// Shared constants and FSM encoding for the nibble-serial 16-bit adder.
package adder_serial16_pkg;

    localparam int NIB_DEF   = 4;
    localparam int NSTEP_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] out,
    output logic       carry
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        out   = p ^ c[3:0];
        carry = c[4];
    end

endmodule

// File: rtl/adder_serial16.sv
// Nibble-serial 16-bit adder: one CLA slice reused over NSTEP cycles.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | adding nibble cnt each cycle
// DONE  | result held, out_valid high until out_ready
module adder_serial16
    import adder_serial16_pkg::*;
#(
    parameter int NIB   = NIB_DEF,
    parameter int NSTEP = NSTEP_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NIB*NSTEP-1:0]  a,
    input  logic [NIB*NSTEP-1:0]  b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NIB*NSTEP-1:0]  sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W = NIB * NSTEP;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic [NIB-1:0] slice_a;
    logic [NIB-1:0] slice_b;
    logic [NIB-1:0] slice_out;
    logic           slice_carry;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NSTEP; i++) begin
            if (cnt_q == 2'(i)) begin
                slice_a = a_q[i*NIB +: NIB];
                slice_b = b_q[i*NIB +: NIB];
            end
        end
    end

    adder_cla4 u_cla (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .out   (slice_out),
        .carry (slice_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < NSTEP; i++) begin
                    if (cnt_q == 2'(i)) begin
                        sum_d[i*NIB +: NIB] = slice_out;
                    end
                end
                carry_d = slice_carry;
                // cnt parks on the last step; only a new accept clears it
                if (cnt_q == 2'(NSTEP - 1)) begin
                    state_d = DONE;
                    cout_d  = slice_carry;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_out[NIB-1] != a_q[W-1]);
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_serial16.sv
// Directed, table-driven bench for the nibble-serial 16-bit adder.
module tb_adder_serial16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        cin_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    adder_serial16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_i      = a;
        b_i      = b;
        cin_i    = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // scrambles operands and in_valid while waiting; returns cycles to out_valid
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            a_i      = 16'($urandom);
            b_i      = 16'($urandom);
            cin_i    = 1'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_release", 32'(in_ready), 32'd1);
        check("out_valid_after_release", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] held_sum;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[8] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = 16'h0;
        b_i       = 16'h0;
        cin_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        for (int i = 0; i < 9; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].cin);
            check("calc_in_ready", 32'(in_ready), 32'd0);
            check("calc_out_valid", 32'(out_valid), 32'd0);
            wait_done(lat);
            check("latency", 32'(lat), 32'd4);
            check("sum", 32'(sum), 32'(vecs[i].exp_sum));
            check("cout", 32'(cout), 32'(vecs[i].exp_cout));
            check("ovf", 32'(ovf), 32'(vecs[i].exp_ovf));
            release_result();
        end

        // idle with in_valid low keeps the last result
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_sum", 32'(sum), 32'hFFFE);
        check("idle_hold_ovf", 32'(ovf), 32'd1);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // back-pressure in DONE: 0x8001+0x0FFF = 0x9000
        accept(16'h8001, 16'h0FFF, 1'b0);
        wait_done(lat);
        check("bp_latency", 32'(lat), 32'd4);
        held_sum = sum;
        check("bp_sum", 32'(held_sum), 32'h9000);
        for (int k = 0; k < 3; k++) begin
            in_valid = ~in_valid;
            a_i      = 16'($urandom);
            b_i      = 16'($urandom);
            @(posedge clk);
            #1;
            check("bp_sum_stable", 32'(sum), 32'h9000);
            check("bp_cout", 32'(cout), 32'd0);
            check("bp_ovf", 32'(ovf), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        // handshake with in_valid high: must not accept on the same edge
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("bp_no_same_edge_accept", 32'(in_ready), 32'd1);

        // reset while cnt==2 in CALC
        accept(16'h1234, 16'h4321, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'h0);
        check("midrst_cout", 32'(cout), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_stays_idle", 32'(out_valid), 32'd0);
        check("midrst_sum_clear", 32'(sum), 32'h0);

        accept(16'h0001, 16'h0001, 1'b0);
        wait_done(lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_sum", 32'(sum), 32'h0002);
        check("post_rst_cout", 32'(cout), 32'd0);
        release_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
